fwd_scoreboard: RTL and testbench
=================================

// Module: fwd_scoreboard
// PURPOSE
//  Parametrised in-flight destination scoreboard replacing hand-coded per-case forwarding/load-use logic.
//  Tracks writers in EX..WB as a shift pipeline of NSTAGE slots; per-slot result-latency countdown.
//  Sits beside ID/EX latch: judges ID operands, raises stall, registers EX-stage forward selects.
// PARAMETERS
//  NREG    32  architectural registers; reg index width RW = $clog2(NREG); reg 0 never tracked
//  NSTAGE  3   back-end slots (0=EX,1=MEM,2=WB); fwd select width SW = $clog2(NSTAGE)
//  LATW    2   width of result-latency field
// PORTS
//  CLK         in   1     clock
//  nRST        in   1     reset, asynchronous, active-low
//  id_valid    in   1     ID holds a real instruction
//  id_rs       in   RW    source A reg
//  id_rt       in   RW    source B reg
//  id_use_rs   in   1     source A actually read
//  id_use_rt   in   1     source B actually read (0 for I-type imm ops)
//  id_wen      in   1     ID instruction writes a register
//  id_dest     in   RW    resolved dest (rd/rt/31 already muxed by caller)
//  id_lat      in   LATW  advances until result forwardable (ALU=1, LW=2)
//  ex_adv      in   1     back end advances this cycle (0 while dmem miss)
//  flush       in   1     squash ID instruction (taken branch/jump)
//  stall       out  1     ID/IF must hold; combinational
//  fwd_a_sel   out  SW    EX operand A: 0=regfile/latched, k=slot k latch output
//  fwd_b_sel   out  SW    EX operand B, same encoding
// BEHAVIOUR
//  Reset: all slots invalid; fwd_a_sel=fwd_b_sel=0; stall=0 (follows empty state).
//  Slot = {valid, wen, dest, lat}. Insert lat = clamp(id_lat, 1, NSTAGE-1); 0 treated as 1.
//  Match (per operand, comb): youngest slot k in 0..NSTAGE-2, valid&wen, dest==src, src!=0, use=1.
//  Slot NSTAGE-1 never matched: regfile is write-before-read.
//  stall = id_valid & ~flush & (matchA.lat>1 | matchB.lat>1); independent of ex_adv.
//  ex_adv=0: every register holds; outputs unchanged.
//  ex_adv=1: slot k -> k+1 with lat-1 (saturate 0); slot NSTAGE-1 drops off.
//   id_valid & ~stall & ~flush: slot0 <= ID entry; fwd_x_sel <= match ? k+1 : 0.
//   else (stall, flush, or ~id_valid): slot0 <= bubble (valid=0); fwd_x_sel <= 0.
//  Simultaneous flush+stall: flush wins, bubble, no stall credit kept.
//  Same dest in two slots: youngest (lowest k) wins.
//  Latency: stall same cycle; fwd sels valid the cycle the instruction is in EX (1 advance later).
//  Load-use (lat=2) in slot0 -> exactly one bubble; retry forwards from slot 2.
//  nRST mid-operation: all slots cleared immediately, in-flight state lost.
// CONFIGURATION
//  FWD_PERF_CNT_EN defined: adds outputs stall_cnt[31:0], fwd_cnt[31:0]; on ex_adv,
//   stall_cnt += stall&id_valid&~flush; fwd_cnt += number of nonzero fwd sels written (0..2).
//   Both reset 0, wrap at 2^32.
//  Undefined: no counters, no extra ports; core behaviour identical.
// STRUCTURE
//  fwd_pkg: slot_t struct, fwd_sel_t, LAT_ALU=1, LAT_LOAD=2 constants.
//  Sub-module fwd_match: priority youngest-match over slots -> {hit, k, lat}; instantiated per operand.
// TESTING
//  1 add r3 (lat1) then sub r4,r3,r5 -> stall=0; next cycle fwd_a_sel=1.
//  2 lw r2 then add r6,r2,r2 -> stall=1 one cycle, bubble in slot0; then fwd_a_sel=fwd_b_sel=2.
//  3 add r7; nop; or r8,r7,r0 -> fwd_a_sel=2, fwd_b_sel=0 (r0 never matched).
//  4 lw r2 in slot0, ID stalled on r2, ex_adv=0 3 cycles -> slots frozen, stall=1 throughout; release after 1 advance.
//  5 add r9,r9 twice back-to-back, then use r9 -> youngest wins, fwd sel=1; flush+stall same cycle -> bubble, fwd sels 0.
//  6 nRST low with 3 valid slots -> all invalid, sels 0; FWD_PERF_CNT_EN: scenario 2 gives stall_cnt=1, fwd_cnt=2.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
// fwd_pkg: shared types and constants for the forwarding scoreboard.
// Slot fields are sized by the default geometry below; the top-level
// parameters default to the same values and must be kept consistent.
package fwd_pkg;

   localparam int NREG_DEF   = 32;
   localparam int NSTAGE_DEF = 3;
   localparam int LATW_DEF   = 2;
   localparam int RW_DEF     = $clog2(NREG_DEF);
   localparam int SW_DEF     = $clog2(NSTAGE_DEF);

   // Advances a result needs before it can be forwarded
   localparam logic [LATW_DEF-1:0] LAT_ALU  = 2'd1;
   localparam logic [LATW_DEF-1:0] LAT_LOAD = 2'd2;

   typedef logic [SW_DEF-1:0] fwd_sel_t;

   typedef struct packed {
      logic                valid;
      logic                wen;
      logic [RW_DEF-1:0]   dest;
      logic [LATW_DEF-1:0] lat;
   } slot_t;

   // Insert latency: 0 behaves as an ALU op, and nothing may outlive the pipe
   function automatic logic [LATW_DEF-1:0] clamp_lat(input logic [LATW_DEF-1:0] lat,
                                                     input logic [LATW_DEF-1:0] max_lat);
      logic [LATW_DEF-1:0] res;
      if (lat < LAT_ALU) begin
         res = LAT_ALU;
      end else if (lat > max_lat) begin
         res = max_lat;
      end else begin
         res = lat;
      end
      return res;
   endfunction

endpackage

// File: rtl/fwd_scoreboard_match.sv
// fwd_match: youngest-first search of the forwardable slots for one source
// operand. The WB slot is never passed in because the regfile writes before
// it is read. Register 0 and unused operands never hit.
module fwd_match
   import fwd_pkg::*;
#(
   parameter int NSTAGE = NSTAGE_DEF,
   parameter int SW     = $clog2(NSTAGE)
) (
   input  slot_t [NSTAGE-2:0]   slots,
   input  logic  [RW_DEF-1:0]   src,
   input  logic                 use_src,
   output logic                 hit,
   output logic  [SW-1:0]       k,
   output logic  [LATW_DEF-1:0] lat
);

   // Priority search: lowest slot index (youngest writer) wins
   always_comb begin
      hit = 1'b0;
      k   = '0;
      lat = '0;
      for (int i = 0; i < NSTAGE - 1; i++) begin
         if (!hit && use_src && (src != '0) && slots[i].valid && slots[i].wen &&
             (slots[i].dest == src)) begin
            hit = 1'b1;
            k   = SW'(i);
            lat = slots[i].lat;
         end else begin
            hit = hit;
         end
      end
   end

endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: in-flight destination scoreboard beside the ID/EX latch.
// Tracks writers in EX..WB, raises a combinational load-use stall and
// registers the EX-stage forward selects (0 = regfile, k = slot k output).
// Optional feature macro: FWD_PERF_CNT_EN adds stall_cnt / fwd_cnt outputs.
module fwd_scoreboard
   import fwd_pkg::*;
#(
   parameter int NREG   = NREG_DEF,
   parameter int NSTAGE = NSTAGE_DEF,
   parameter int LATW   = LATW_DEF,
   localparam int RW    = $clog2(NREG),
   localparam int SW    = $clog2(NSTAGE)
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic            id_valid,
   input  logic [RW-1:0]   id_rs,
   input  logic [RW-1:0]   id_rt,
   input  logic            id_use_rs,
   input  logic            id_use_rt,
   input  logic            id_wen,
   input  logic [RW-1:0]   id_dest,
   input  logic [LATW-1:0] id_lat,
   input  logic            ex_adv,
   input  logic            flush,
   output logic            stall,
   output logic [SW-1:0]   fwd_a_sel,
   output logic [SW-1:0]   fwd_b_sel
`ifdef FWD_PERF_CNT_EN
   ,
   output logic [31:0]     stall_cnt,
   output logic [31:0]     fwd_cnt
`endif
);

   slot_t [NSTAGE-1:0]  slot_q, slot_d;
   logic  [SW-1:0]      fwd_a_q, fwd_a_d;
   logic  [SW-1:0]      fwd_b_q, fwd_b_d;

   logic                hit_a, hit_b;
   logic  [SW-1:0]      k_a, k_b;
   logic  [LATW-1:0]    lat_a, lat_b;
   logic                issue;

   fwd_match #(.NSTAGE(NSTAGE), .SW(SW)) u_match_a (
      .slots   (slot_q[NSTAGE-2:0]),
      .src     (id_rs),
      .use_src (id_use_rs),
      .hit     (hit_a),
      .k       (k_a),
      .lat     (lat_a)
   );

   fwd_match #(.NSTAGE(NSTAGE), .SW(SW)) u_match_b (
      .slots   (slot_q[NSTAGE-2:0]),
      .src     (id_rt),
      .use_src (id_use_rt),
      .hit     (hit_b),
      .k       (k_b),
      .lat     (lat_b)
   );

   // A matched producer that still needs more than one advance blocks ID
   assign stall = id_valid & ~flush & ((hit_a & (lat_a > LAT_ALU)) | (hit_b & (lat_b > LAT_ALU)));
   assign issue = id_valid & ~stall & ~flush;

   // Next state: shift slots on advance, insert ID entry or a bubble into slot 0
   always_comb begin
      slot_d  = slot_q;
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
      if (ex_adv) begin
         for (int s = NSTAGE - 1; s >= 1; s--) begin
            slot_d[s] = slot_q[s-1];
            if (slot_q[s-1].lat != '0) begin
               slot_d[s].lat = slot_q[s-1].lat - LATW'(1);
            end else begin
               slot_d[s].lat = '0;
            end
         end
         if (issue) begin
            slot_d[0].valid = 1'b1;
            slot_d[0].wen   = id_wen;
            slot_d[0].dest  = id_dest;
            slot_d[0].lat   = clamp_lat(id_lat, LATW'(NSTAGE - 1));
            fwd_a_d = hit_a ? (k_a + SW'(1)) : '0;
            fwd_b_d = hit_b ? (k_b + SW'(1)) : '0;
         end else begin
            slot_d[0] = '0;
            fwd_a_d   = '0;
            fwd_b_d   = '0;
         end
      end else begin
         slot_d = slot_q;
      end
   end

   // Slot pipeline and forward-select registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         slot_q  <= '0;
         fwd_a_q <= '0;
         fwd_b_q <= '0;
      end else begin
         slot_q  <= slot_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end

   assign fwd_a_sel = fwd_a_q;
   assign fwd_b_sel = fwd_b_q;

`ifdef FWD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] fwd_cnt_q, fwd_cnt_d;

   // Count stalled ID cycles and nonzero forward selects written, per advance
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (ex_adv) begin
         stall_cnt_d = stall_cnt_q + {31'd0, stall};
         fwd_cnt_d   = fwd_cnt_q + {31'd0, (fwd_a_d != '0)} + {31'd0, (fwd_b_d != '0)};
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Performance counter registers, wrapping naturally at 2^32
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt_q <= 32'd0;
         fwd_cnt_q   <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed self-checking bench for fwd_scoreboard (default 32 regs, 3 slots).
module tb_fwd_scoreboard;
   import fwd_pkg::*;

   logic       CLK;
   logic       nRST;
   logic       id_valid;
   logic [4:0] id_rs, id_rt, id_dest;
   logic       id_use_rs, id_use_rt, id_wen;
   logic [1:0] id_lat;
   logic       ex_adv, flush;
   logic       stall;
   logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef FWD_PERF_CNT_EN
   logic [31:0] stall_cnt, fwd_cnt;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   fwd_scoreboard dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .id_valid  (id_valid),
      .id_rs     (id_rs),
      .id_rt     (id_rt),
      .id_use_rs (id_use_rs),
      .id_use_rt (id_use_rt),
      .id_wen    (id_wen),
      .id_dest   (id_dest),
      .id_lat    (id_lat),
      .ex_adv    (ex_adv),
      .flush     (flush),
      .stall     (stall),
      .fwd_a_sel (fwd_a_sel),
      .fwd_b_sel (fwd_b_sel)
`ifdef FWD_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .fwd_cnt   (fwd_cnt)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic wen, input logic [4:0] dest,
                         input logic [1:0] lat);
      id_valid  = 1'b1;
      id_rs     = rs;
      id_rt     = rt;
      id_use_rs = urs;
      id_use_rt = urt;
      id_wen    = wen;
      id_dest   = dest;
      id_lat    = lat;
   endtask

   task automatic idle();
      id_valid  = 1'b0;
      id_rs     = 5'd0;
      id_rt     = 5'd0;
      id_use_rs = 1'b0;
      id_use_rt = 1'b0;
      id_wen    = 1'b0;
      id_dest   = 5'd0;
      id_lat    = 2'd0;
   endtask

   task automatic do_reset();
      idle();
      ex_adv = 1'b1;
      flush  = 1'b0;
      nRST   = 1'b0;
      cyc();
      cyc();
      nRST = 1'b1;
   endtask

   task automatic test_reset();
      idle();
      ex_adv = 1'b1;
      flush  = 1'b0;
      nRST   = 1'b0;
      cyc();
      cyc();
      total_cnt++;
      if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0)
         $display("FAIL reset_sels: got a=%0d b=%0d want a=0 b=0", fwd_a_sel, fwd_b_sel);
      else pass_cnt++;
      nRST = 1'b1;
      set_id(5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd5, LAT_LOAD);
      #1;
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall);
      else pass_cnt++;
`ifdef FWD_PERF_CNT_EN
      total_cnt++;
      if (stall_cnt !== 32'd0 || fwd_cnt !== 32'd0)
         $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, fwd_cnt);
      else pass_cnt++;
`endif
      idle();
   endtask

   task automatic test_alu_fwd();
      do_reset();
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, LAT_ALU);   // add r3,r1,r2
      cyc();
      set_id(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, LAT_ALU);   // sub r4,r3,r5
      #1;
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL alu_stall: got %b want 0", stall);
      else pass_cnt++;
      cyc();
      idle();
      total_cnt++;
      if (fwd_a_sel !== 2'd1 || fwd_b_sel !== 2'd0)
         $display("FAIL alu_fwd: got a=%0d b=%0d want a=1 b=0", fwd_a_sel, fwd_b_sel);
      else pass_cnt++;
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, LAT_LOAD);  // lw r2
      cyc();
      set_id(5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6, LAT_ALU);   // add r6,r2,r2
      #1;
      total_cnt++;
      if (stall !== 1'b1) $display("FAIL ldu_stall1: got %b want 1", stall);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (stall !== 1'b0 || fwd_a_sel !== 2'd0)
         $display("FAIL ldu_bubble: got stall=%b a=%0d want stall=0 a=0", stall, fwd_a_sel);
      else pass_cnt++;
      cyc();
      idle();
      total_cnt++;
      if (fwd_a_sel !== 2'd2 || fwd_b_sel !== 2'd2)
         $display("FAIL ldu_fwd: got a=%0d b=%0d want a=2 b=2", fwd_a_sel, fwd_b_sel);
      else pass_cnt++;
`ifdef FWD_PERF_CNT_EN
      total_cnt++;
      if (stall_cnt !== 32'd1 || fwd_cnt !== 32'd2)
         $display("FAIL ldu_cnt: got %0d/%0d want 1/2", stall_cnt, fwd_cnt);
      else pass_cnt++;
`endif
   endtask

   task automatic test_r0_and_gap();
      do_reset();
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd7, LAT_ALU);   // add r7
      cyc();
      idle();                                                // nop
      cyc();
      set_id(5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 5'd8, LAT_ALU);   // or r8,r7,r0
      #1;
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL r0_stall: got %b want 0", stall);
      else pass_cnt++;
      cyc();
      idle();
      total_cnt++;
      if (fwd_a_sel !== 2'd2 || fwd_b_sel !== 2'd0)
         $display("FAIL r0_fwd: got a=%0d b=%0d want a=2 b=0", fwd_a_sel, fwd_b_sel);
      else pass_cnt++;
   endtask

   task automatic test_freeze();
      do_reset();
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, LAT_ALU);   // add r5
      cyc();
      set_id(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, LAT_LOAD);  // lw r2,(r5)
      cyc();
      total_cnt++;
      if (fwd_a_sel !== 2'd1) $display("FAIL frz_lw_fwd: got %0d want 1", fwd_a_sel);
      else pass_cnt++;
      set_id(5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 5'd6, LAT_ALU);   // add r6,r2,r0
      ex_adv = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total_cnt++;
         if (stall !== 1'b1) $display("FAIL frz_stall%0d: got %b want 1", i, stall);
         else pass_cnt++;
         cyc();
         total_cnt++;
         if (fwd_a_sel !== 2'd1) $display("FAIL frz_hold%0d: got %0d want 1", i, fwd_a_sel);
         else pass_cnt++;
      end
      ex_adv = 1'b1;
      #1;
      total_cnt++;
      if (stall !== 1'b1) $display("FAIL frz_adv_stall: got %b want 1", stall);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (stall !== 1'b0 || fwd_a_sel !== 2'd0)
         $display("FAIL frz_release: got stall=%b a=%0d want stall=0 a=0", stall, fwd_a_sel);
      else pass_cnt++;
      cyc();
      idle();
      total_cnt++;
      if (fwd_a_sel !== 2'd2 || fwd_b_sel !== 2'd0)
         $display("FAIL frz_fwd: got a=%0d b=%0d want a=2 b=0", fwd_a_sel, fwd_b_sel);
      else pass_cnt++;
   endtask

   task automatic test_youngest_flush();
      do_reset();
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd9, LAT_ALU);   // add r9,r1,r2
      cyc();
      set_id(5'd9, 5'd1, 1'b1, 1'b1, 1'b1, 5'd9, LAT_ALU);   // add r9,r9,r1
      cyc();
      total_cnt++;
      if (fwd_a_sel !== 2'd1) $display("FAIL yng_chain: got %0d want 1", fwd_a_sel);
      else pass_cnt++;
      set_id(5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, LAT_ALU);   // use r9 twice, no write
      cyc();
      total_cnt++;
      if (fwd_a_sel !== 2'd1 || fwd_b_sel !== 2'd1)
         $display("FAIL yng_fwd: got a=%0d b=%0d want a=1 b=1", fwd_a_sel, fwd_b_sel);
      else pass_cnt++;
      set_id(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, LAT_LOAD);  // lw r2,(r9)
      cyc();
      total_cnt++;
      if (fwd_a_sel !== 2'd2) $display("FAIL yng_lw_fwd: got %0d want 2", fwd_a_sel);
      else pass_cnt++;
      set_id(5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6, LAT_ALU);   // dependent add, squashed
      flush = 1'b1;
      #1;
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL flush_stall: got %b want 0", stall);
      else pass_cnt++;
      cyc();
      flush = 1'b0;
      total_cnt++;
      if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0)
         $display("FAIL flush_sels: got a=%0d b=%0d want a=0 b=0", fwd_a_sel, fwd_b_sel);
      else pass_cnt++;
      #1;
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL flush_after: got %b want 0", stall);
      else pass_cnt++;
      cyc();
      idle();
      total_cnt++;
      if (fwd_a_sel !== 2'd2 || fwd_b_sel !== 2'd2)
         $display("FAIL flush_retry: got a=%0d b=%0d want a=2 b=2", fwd_a_sel, fwd_b_sel);
      else pass_cnt++;
   endtask

   task automatic test_lat_clamp();
      do_reset();
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd13, 2'd3);     // lat 3 clamps to 2
      cyc();
      set_id(5'd13, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, LAT_ALU);
      #1;
      total_cnt++;
      if (stall !== 1'b1) $display("FAIL clamp_stall: got %b want 1", stall);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL clamp_release: got %b want 0", stall);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (fwd_a_sel !== 2'd2) $display("FAIL clamp_fwd: got %0d want 2", fwd_a_sel);
      else pass_cnt++;
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd14, 2'd0);     // lat 0 acts as 1
      cyc();
      set_id(5'd0, 5'd14, 1'b0, 1'b1, 1'b1, 5'd4, LAT_ALU);
      #1;
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL lat0_stall: got %b want 0", stall);
      else pass_cnt++;
      cyc();
      idle();
      total_cnt++;
      if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd1)
         $display("FAIL lat0_fwd: got a=%0d b=%0d want a=0 b=1", fwd_a_sel, fwd_b_sel);
      else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      do_reset();
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd10, LAT_ALU);
      cyc();
      set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd11, LAT_ALU);
      cyc();
      set_id(5'd11, 5'd2, 1'b1, 1'b1, 1'b1, 5'd12, LAT_ALU);
      cyc();
      total_cnt++;
      if (fwd_a_sel !== 2'd1) $display("FAIL mrst_pre: got %0d want 1", fwd_a_sel);
      else pass_cnt++;
      set_id(5'd12, 5'd11, 1'b1, 1'b1, 1'b1, 5'd15, LAT_ALU);
      nRST = 1'b0;
      #1;
      total_cnt++;
      if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0)
         $display("FAIL mrst_async: got a=%0d b=%0d want a=0 b=0", fwd_a_sel, fwd_b_sel);
      else pass_cnt++;
      cyc();
      nRST = 1'b1;
      cyc();
      idle();
      total_cnt++;
      if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0)
         $display("FAIL mrst_cleared: got a=%0d b=%0d want a=0 b=0", fwd_a_sel, fwd_b_sel);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_alu_fwd();
      test_load_use();
      test_r0_and_gap();
      test_freeze();
      test_youngest_flush();
      test_lat_clamp();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
